// File: rtl/d_ff_pkg.sv
// rtl/d_ff_pkg.sv - shared constants and helpers for the D-register pipeline
package d_ff_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Ceiling log2, never less than 1 so a counter always has at least one bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/d_ff_stage.sv
// rtl/d_ff_stage.sv - one valid+data register stage with load, drain and clear
module d_ff_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // Load wins over drain so a stage can hand off and refill on the same edge;
  // data only changes on a load so idle stages never toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else if (clr) begin
      valid <= 1'b0;
      q     <= RESET_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/d_ff_pipe.sv
// rtl/d_ff_pipe.sv - DEPTH-stage valid/ready register pipeline with bubble collapse
module d_ff_pipe
  import d_ff_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data [DEPTH];
  logic             push;
  logic             pop;

  // Advance chain runs from the head backwards: a stage moves on if the next
  // slot is empty or is itself moving, which is what collapses bubbles.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = valid[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = valid[i] & (~valid[i+1] | adv[i+1]);
    end
  end

  assign in_ready  = ~valid[0] | adv[0];
  assign push      = in_valid & in_ready;
  assign pop       = adv[DEPTH-1];
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign load[i] = push;
      d_ff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (load[i]),
        .drain (adv[i]),
        .d     (in_data),
        .valid (valid[i]),
        .q     (data[i])
      );
    end else begin : g_body
      assign load[i] = adv[i-1];
      d_ff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load  (load[i]),
        .drain (adv[i]),
        .d     (data[i-1]),
        .valid (valid[i]),
        .q     (data[i])
      );
    end
  end

  // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_d_ff_pipe.sv
// tb/tb_d_ff_pipe.sv - directed table-driven bench for d_ff_pipe (D=4 and D=1)
module tb_d_ff_pipe;

  typedef struct {
    logic       clr;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [2:0] cnt;
  } vec_t;

  logic       clk;
  logic       rst_n;

  logic       clr4, iv4, ir4, ov4, ordy4;
  logic [7:0] id4, od4;
  logic [2:0] cnt4;

  logic       clr1, iv1, ir1, ov1, ordy1;
  logic [7:0] id1, od1;
  logic [0:0] cnt1;

  int total;
  int bad;

  vec_t tab4 [22];
  vec_t tab1 [5];

  d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr4),
    .in_valid  (iv4),
    .in_data   (id4),
    .in_ready  (ir4),
    .out_valid (ov4),
    .out_data  (od4),
    .out_ready (ordy4),
    .count     (cnt4)
  );

  d_ff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr1),
    .in_valid  (iv1),
    .in_data   (id1),
    .in_ready  (ir1),
    .out_valid (ov1),
    .out_data  (od1),
    .out_ready (ordy1),
    .count     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, input logic v, input logic [7:0] d, input logic r,
                              input logic eir, input logic eov, input logic [7:0] eod,
                              input logic [2:0] ecnt);
    vec_t t;
    t.clr = c; t.iv = v; t.id = d; t.ordy = r;
    t.ir = eir; t.ov = eov; t.od = eod; t.cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input bit single, input int idx);
    @(negedge clk);
    if (single) begin
      clr1 = t.clr; iv1 = t.iv; id1 = t.id; ordy1 = t.ordy;
      #1;
      chk($sformatf("d1[%0d].in_ready", idx), {31'd0, ir1}, {31'd0, t.ir});
      chk($sformatf("d1[%0d].out_valid", idx), {31'd0, ov1}, {31'd0, t.ov});
      chk($sformatf("d1[%0d].out_data", idx), {24'd0, od1}, {24'd0, t.od});
      chk($sformatf("d1[%0d].count", idx), {31'd0, cnt1}, {29'd0, t.cnt});
    end else begin
      clr4 = t.clr; iv4 = t.iv; id4 = t.id; ordy4 = t.ordy;
      #1;
      chk($sformatf("d4[%0d].in_ready", idx), {31'd0, ir4}, {31'd0, t.ir});
      chk($sformatf("d4[%0d].out_valid", idx), {31'd0, ov4}, {31'd0, t.ov});
      if (t.ov || idx == 0 || t.clr == 1'b0)
        chk($sformatf("d4[%0d].out_data", idx), {24'd0, od4}, {24'd0, t.od});
      chk($sformatf("d4[%0d].count", idx), {29'd0, cnt4}, {29'd0, t.cnt});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clr4 = 0; iv4 = 0; id4 = 0; ordy4 = 0;
    clr1 = 0; iv1 = 0; id1 = 0; ordy1 = 0;

    // D=4 table: bubble collapse, backpressure fill, full push+pop, drain, clear
    tab4[0]  = mk(0, 1, 8'hA1, 0,  1, 0, 8'h5A, 0);
    tab4[1]  = mk(0, 0, 8'h00, 0,  1, 0, 8'h5A, 1);
    tab4[2]  = mk(0, 0, 8'h00, 0,  1, 0, 8'h5A, 1);
    tab4[3]  = mk(0, 1, 8'hB2, 0,  1, 0, 8'h5A, 1);
    tab4[4]  = mk(0, 0, 8'h00, 0,  1, 1, 8'hA1, 2);
    tab4[5]  = mk(0, 0, 8'h00, 0,  1, 1, 8'hA1, 2);
    tab4[6]  = mk(0, 0, 8'h00, 0,  1, 1, 8'hA1, 2);
    tab4[7]  = mk(0, 0, 8'h00, 1,  1, 1, 8'hA1, 2);
    tab4[8]  = mk(0, 0, 8'h00, 1,  1, 1, 8'hB2, 1);
    tab4[9]  = mk(0, 0, 8'h00, 1,  1, 0, 8'hB2, 0);
    tab4[10] = mk(0, 1, 8'hC0, 0,  1, 0, 8'hB2, 0);
    tab4[11] = mk(0, 1, 8'hC1, 0,  1, 0, 8'hB2, 1);
    tab4[12] = mk(0, 1, 8'hC2, 0,  1, 0, 8'hB2, 2);
    tab4[13] = mk(0, 1, 8'hC3, 0,  1, 0, 8'hB2, 3);
    tab4[14] = mk(0, 1, 8'hC4, 0,  0, 1, 8'hC0, 4);
    tab4[15] = mk(0, 1, 8'hC5, 0,  0, 1, 8'hC0, 4);
    tab4[16] = mk(0, 1, 8'hC6, 1,  1, 1, 8'hC0, 4);
    tab4[17] = mk(0, 0, 8'h00, 1,  1, 1, 8'hC1, 4);
    tab4[18] = mk(0, 0, 8'h00, 1,  1, 1, 8'hC2, 3);
    tab4[19] = mk(1, 1, 8'hEE, 0,  1, 1, 8'hC3, 2);
    tab4[20] = mk(0, 0, 8'h00, 1,  1, 0, 8'h5A, 0);
    tab4[21] = mk(0, 0, 8'h00, 1,  1, 0, 8'h5A, 0);

    // D=1 table: single-stage ready path, push+pop when full, clear with offer
    tab1[0] = mk(0, 1, 8'h11, 0,  1, 0, 8'h00, 0);
    tab1[1] = mk(0, 1, 8'h22, 0,  0, 1, 8'h11, 1);
    tab1[2] = mk(0, 1, 8'h22, 1,  1, 1, 8'h11, 1);
    tab1[3] = mk(1, 1, 8'h33, 0,  0, 1, 8'h22, 1);
    tab1[4] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0);

    // Reset state
    #12;
    chk("rst.out_valid", {31'd0, ov4}, 32'd0);
    chk("rst.out_data", {24'd0, od4}, 32'h5A);
    chk("rst.count", {29'd0, cnt4}, 32'd0);
    chk("rst.in_ready", {31'd0, ir4}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) apply(tab4[i], 1'b0, i);

    // Streaming: 0x01..0x10 back to back, head always ready
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      clr4  = 1'b0;
      ordy4 = 1'b1;
      iv4   = (k < 16);
      id4   = (k < 16) ? 8'(k + 1) : 8'h00;
      #1;
      if (k < 16) chk($sformatf("stream[%0d].in_ready", k), {31'd0, ir4}, 32'd1);
      if (k <= 16) chk($sformatf("stream[%0d].count", k), {29'd0, cnt4}, (k < 4) ? k : 4);
      chk($sformatf("stream[%0d].out_valid", k), {31'd0, ov4}, (k >= 4) ? 32'd1 : 32'd0);
      if (k >= 4) chk($sformatf("stream[%0d].out_data", k), {24'd0, od4}, k - 3);
    end

    // Mid-stream async reset with three words held
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      iv4 = 1'b1; id4 = 8'(8'h70 + k); ordy4 = 1'b0;
    end
    @(negedge clk);
    iv4 = 1'b0;
    #1;
    chk("midrst.pre_count", {29'd0, cnt4}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", {31'd0, ov4}, 32'd0);
    chk("midrst.count", {29'd0, cnt4}, 32'd0);
    chk("midrst.out_data", {24'd0, od4}, 32'h5A);
    chk("midrst.in_ready", {31'd0, ir4}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply(tab1[i], 1'b1, i);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
